// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link (demux receiver and mux transmitter).
// State encoding, default geometry and channel-slice helper.
package tdm_demux_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Low bit index of channel k inside a flat NUM_CH*DATA_W bus.
    function automatic int ch_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/tdm_demux_shift_deser.sv
// Serial-to-parallel word assembler: bits enter at the LSB, word completes combinationally on the last bit.
// Word and done flag are valid in the cycle of the final bit; no backpressure (one bit per cycle).
module tdm_demux_shift_deser
    import tdm_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic              i_last,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_word,
    output logic              o_done
);

    // Only DATA_W-1 bits need storing: the final bit is taken straight from the line.
    logic [DATA_W-2:0] r_shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= {{(DATA_W-2){1'b0}}, i_bit};
        end else if (i_shift) begin
            r_shift <= {r_shift[DATA_W-3:0], i_bit};
        end
    end

    assign o_word = {r_shift, i_bit};
    assign o_done = i_shift & i_last;

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: recovers NUM_CH serial MSB-first words per sync-marked frame into registered outputs.
// Word/strobe registered on the edge that samples the last bit; no backpressure (line-rate input).
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sync_in,
    input  logic                     data_in,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     frame_done,
    output logic                     sync_err
);

    localparam int BW = $clog2(DATA_W);
    localparam int CW = $clog2(NUM_CH);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [BW-1:0]              r_bit_cnt;
    logic [CW-1:0]              r_ch_cnt;
    logic [NUM_CH*DATA_W-1:0]   r_ch_data;
    logic [NUM_CH-1:0]          r_ch_valid;
    logic                       r_frame_done;
    logic                       r_sync_err;

    logic                       w_shift;
    logic                       w_restart;
    logic                       w_last;
    logic                       w_fin;
    logic                       w_word_done;
    logic [DATA_W-1:0]          w_word;

    tdm_demux_shift_deser #(
        .DATA_W (DATA_W)
    ) u_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (sync_in),
        .i_shift (w_shift),
        .i_last  (w_last),
        .i_bit   (data_in),
        .o_word  (w_word),
        .o_done  (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (sync_in) w_state_nxt = SHIFT;
            SHIFT:   if (w_fin)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A sync seen while shifting overrides everything else: the frame restarts.
    always_comb begin
        w_shift   = 1'b0;
        w_restart = 1'b0;
        if (r_state == SHIFT) begin
            w_shift   = !sync_in;
            w_restart = sync_in;
        end
    end

    assign w_last = (r_bit_cnt == BIT_LAST);
    assign w_fin  = w_word_done && (r_ch_cnt == CH_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_ch_cnt     <= '0;
            r_ch_data    <= '0;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= w_restart;
            if (sync_in) begin
                r_bit_cnt <= BW'(1);
                r_ch_cnt  <= '0;
            end else if (w_shift) begin
                if (w_word_done) begin
                    r_bit_cnt <= '0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (r_ch_cnt == CW'(k)) begin
                            r_ch_data[ch_lo(k, DATA_W) +: DATA_W] <= w_word;
                            r_ch_valid[k] <= 1'b1;
                        end
                    end
                    if (w_fin) begin
                        r_frame_done <= 1'b1;
                    end else begin
                        r_ch_cnt <= r_ch_cnt + 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign ch_data    = r_ch_data;
    assign ch_valid   = r_ch_valid;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frames plus random traffic against a bit-queue reference model.
module tb_tdm_demux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int TW     = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sync_in = 1'b0;
    logic              data_in = 1'b0;
    logic [TW-1:0]     ch_data;
    logic [NUM_CH-1:0] ch_valid;
    logic              frame_done;
    logic              sync_err;

    tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_in    (sync_in),
        .data_in    (data_in),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc_no = 0;

    // Reference model: the frame is just the list of bits received since the last sync.
    logic [TW-1:0]     m_data   = '0;
    logic [NUM_CH-1:0] m_valid  = '0;
    logic              m_done   = 1'b0;
    logic              m_err    = 1'b0;
    bit                m_active = 1'b0;
    bit                m_bits[$];

    int                done_cnt = 0;
    int                err_cnt  = 0;
    int                last_done_cyc = 0;
    int                prev_done_cyc = 0;
    logic [NUM_CH-1:0] valid_seen = '0;
    int                pulse_cyc[NUM_CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic d);
        int n, k;
        logic [DATA_W-1:0] w;
        m_valid = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (!r) begin
            m_data   = '0;
            m_active = 1'b0;
            m_bits.delete();
        end else if (s) begin
            m_err    = m_active;
            m_active = 1'b1;
            m_bits.delete();
            m_bits.push_back(d);
        end else if (m_active) begin
            m_bits.push_back(d);
            n = m_bits.size();
            if (n % DATA_W == 0) begin
                k = n / DATA_W - 1;
                w = '0;
                for (int j = 0; j < DATA_W; j++) w = {w[DATA_W-2:0], m_bits[n-DATA_W+j]};
                m_data[k*DATA_W +: DATA_W] = w;
                m_valid[k] = 1'b1;
                if (k == NUM_CH - 1) begin
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic d);
        rst_n   = r;
        sync_in = s;
        data_in = d;
        @(posedge clk);
        model_step(r, s, d);
        cyc_no++;
        #1;
        check("ch_data",    64'(ch_data),    64'(m_data));
        check("ch_valid",   64'(ch_valid),   64'(m_valid));
        check("frame_done", 64'(frame_done), 64'(m_done));
        check("sync_err",   64'(sync_err),   64'(m_err));
        if (frame_done) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc_no;
        end
        if (sync_err) err_cnt++;
        valid_seen |= ch_valid;
        for (int k = 0; k < NUM_CH; k++) if (ch_valid[k]) pulse_cyc[k] = cyc_no;
    endtask

    // Sends the first nbits of frame f (channel 0 in the low byte), sync on bit 0.
    task automatic send_frame(input logic [TW-1:0] f, input int nbits);
        int c, b;
        for (int i = 0; i < nbits; i++) begin
            c = i / DATA_W;
            b = i % DATA_W;
            tick(1'b1, (i == 0), f[c*DATA_W + (DATA_W-1-b)]);
        end
    endtask

    initial begin
        int start, d0, e0;
        logic [TW-1:0] rf;

        // Reset with random line activity
        for (int i = 0; i < 2; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("rst_data",  64'(ch_data), 64'(0));
        check("rst_valid", 64'(ch_valid), 64'(0));

        // Nominal frame right after release
        start = cyc_no;
        done_cnt = 0;
        send_frame({8'h00, 8'hFF, 8'h3C, 8'hA5}, TW);
        check("nom_data", 64'(ch_data), 64'(32'h00FF3CA5));
        for (int k = 0; k < NUM_CH; k++)
            check("nom_pulse_cyc", 64'(pulse_cyc[k] - start), 64'(DATA_W * (k + 1)));
        check("nom_done_cyc", 64'(last_done_cyc), 64'(pulse_cyc[NUM_CH-1]));
        check("nom_done_cnt", 64'(done_cnt), 64'(1));

        // Back-to-back frames
        done_cnt = 0;
        err_cnt  = 0;
        send_frame({8'h00, 8'hFF, 8'h3C, 8'hA5}, TW);
        send_frame({8'h44, 8'h33, 8'h22, 8'h11}, TW);
        check("b2b_data", 64'(ch_data), 64'(32'h44332211));
        check("b2b_done_cnt", 64'(done_cnt), 64'(2));
        check("b2b_done_gap", 64'(last_done_cyc - prev_done_cyc), 64'(TW));
        check("b2b_err_cnt", 64'(err_cnt), 64'(0));

        // Mid-frame sync at bit 4 of channel 1
        valid_seen = '0;
        err_cnt    = 0;
        done_cnt   = 0;
        send_frame({8'h78, 8'h56, 8'h34, 8'h12}, DATA_W + 4);
        check("mid_valid_seen", 64'(valid_seen), 64'(4'b0001));
        check("mid_partial_data", 64'(ch_data), 64'(32'h44332212));
        send_frame({8'hF0, 8'hDE, 8'hBC, 8'h9A}, TW);
        check("mid_err_cnt", 64'(err_cnt), 64'(1));
        check("mid_done_cnt", 64'(done_cnt), 64'(1));
        check("mid_data", 64'(ch_data), 64'(32'hF0DEBC9A));

        // Idle noise
        valid_seen = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 50; i++) tick(1'b1, 1'b0, 1'(i % 2));
        check("idle_data", 64'(ch_data), 64'(32'hF0DEBC9A));
        check("idle_valid_seen", 64'(valid_seen), 64'(0));
        check("idle_done", 64'(done_cnt - d0), 64'(0));
        check("idle_err", 64'(err_cnt - e0), 64'(0));

        // Reset after channel 1 completes
        d0 = done_cnt;
        send_frame({8'h01, 8'h02, 8'h03, 8'h04}, 2 * DATA_W);
        tick(1'b0, 1'b0, 1'b1);
        check("rstmid_data", 64'(ch_data), 64'(0));
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        check("rstmid_done", 64'(done_cnt - d0), 64'(0));
        send_frame({8'hDE, 8'hAD, 8'hBE, 8'hEF}, TW);
        check("rstmid_next_data", 64'(ch_data), 64'(32'hDEADBEEF));

        // Sync coinciding with the final bit of a frame
        d0 = done_cnt;
        e0 = err_cnt;
        valid_seen = '0;
        send_frame({8'h55, 8'h66, 8'h77, 8'h88}, TW - 1);
        check("lastbit_valid_seen", 64'(valid_seen), 64'(4'b0111));
        send_frame({8'hA1, 8'hB2, 8'hC3, 8'hD4}, TW);
        check("lastbit_err", 64'(err_cnt - e0), 64'(1));
        check("lastbit_done", 64'(done_cnt - d0), 64'(1));
        check("lastbit_data", 64'(ch_data), 64'(32'hA1B2C3D4));

        // Random traffic: random frames, random syncs, occasional reset
        for (int f = 0; f < 12; f++) begin
            rf = TW'({$urandom, $urandom});
            send_frame(rf, $urandom_range(DATA_W, TW));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                tick(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 600; i++)
            tick(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
